laser_beam_sensor: RTL
======================

// Module: laser_beam_sensor
// PURPOSE
//  Parametrised successor to the fixed 8-input photodiode conduit: N laser-beam photodiode channels plus pedal.
//  Inputs are synchronised and debounced; each beam break/restore becomes a timestamped event in a FIFO.
//  Avalon-MM slave on the HPS lightweight bridge, with an IRQ when events are pending.
// PARAMETERS
//  NUM_CHANNELS     8     photodiode channels, 1..32
//  DEBOUNCE_CYCLES  50000 stable cycles before a state change is accepted (>=2)
//  FIFO_DEPTH       16    event FIFO entries, power of two, >=2
//  TS_PRESCALE      50000 clk cycles per timestamp tick (TIMESTAMP_EN only)
// PORTS
//  clk              in   1   system clock
//  reset            in   1   synchronous, active-high reset
//  photodiode       in   NUM_CHANNELS  raw beam inputs, async; 1 = beam broken
//  pedal            in   1   raw sustain pedal, async; 1 = pressed
//  avs_address      in   2   register word address
//  avs_read         in   1   read strobe
//  avs_write        in   1   write strobe
//  avs_writedata    in   32  write data
//  avs_readdata     out  32  read data, fixed read latency 1
//  irq              out  1   level interrupt
// BEHAVIOUR
//  Reset (synchronous, active-high): avs_readdata=0, irq=0, FIFO empty, overflow=0, debounced states=0, counters=0, CTRL=enable-all/irq-off.
//  Sync: every photodiode bit and pedal pass through 2 flops; no logic sees raw inputs.
//  Debounce per channel: synced != state -> counter++; synced == state -> counter=0.
//   Counter reaching DEBOUNCE_CYCLES-1 makes the channel pending; counter saturates.
//   Pending + enabled: flip state and push event only when granted.
//   Pending + disabled: flip state immediately, push nothing.
//  Push arbiter: at most one push per cycle; lowest pending enabled index wins; others stay pending.
//   Simultaneous changes therefore drain on consecutive cycles in ascending channel order.
//  Pedal: debounced identically; never pushes events.
//  Event word: [4:0] channel, [8] 1=break/0=restore, [9] debounced pedal at push, [31] valid=1, all others 0.
//  Registers (reads registered, data valid the cycle after avs_read):
//   0 STATE  R   [N-1:0] debounced beam states, [31] debounced pedal.
//   1 EVENT  R   FIFO head; read when non-empty pops it. Read when empty returns 0 with no pop.
//   2 COUNT  R   [15:0] occupancy, [16] sticky overflow. Any write flushes the FIFO and clears overflow.
//   3 CTRL   RW  [N-1:0] channel enable (reset all 1s), [31] irq_en (reset 0). Other bits read 0.
//  FIFO full + push: event dropped, overflow set; state still flips.
//  Push + pop in one cycle: both succeed, count unchanged, including when full.
//  Write to COUNT in the same cycle as a push: flush wins and the push is discarded.
//  irq = irq_en & ~empty, registered (asserts 1 cycle after the condition).
//  Writes to address 0/1 are ignored. Reset mid-debounce discards the count and pending state.
// CONFIGURATION
//  TIMESTAMP_EN defined:
//   15-bit counter, +1 every TS_PRESCALE cycles, wraps 0x7FFF -> 0.
//   Value at push stored in event [30:16]; reset 0.
//  TIMESTAMP_EN undefined: event [30:16] = 0; no prescaler or counter logic.
// STRUCTURE
//  Package laser_beam_sensor_pkg: register address localparams, event field offsets/widths, CTRL bit indices.
//  Sub-module beam_debounce: one channel sync + counter + pending; generated NUM_CHANNELS+1 times (last = pedal).
//  FIFO, arbiter and register file stay in the top level.
// TESTING (NUM_CHANNELS=8, DEBOUNCE_CYCLES=4, FIFO_DEPTH=4, TS_PRESCALE=2)
//  Reset, then read CTRL/COUNT/EVENT -> 0x000000FF / 0x00000000 / 0x00000000; irq=0.
//  ch3 held 1 for 10 cycles -> EVENT reads 0x80000103, STATE reads 0x00000008.
//  ch2 pulsed 1 for 2 cycles -> no event, COUNT stays 0.
//  ch1 and ch5 rise same cycle -> EVENT 0x80000101 then 0x80000105.
//  6 breaks with FIFO_DEPTH=4 -> COUNT 0x00010004 and first event retained; then write COUNT -> 0x00000000.
//  CTRL=0x800000FF, break ch0 -> irq=1; pop -> irq=0; CTRL=0xFE, break ch0 -> no event.

Source files
------------

// File: rtl/laser_beam_sensor_pkg.sv
// Shared register map, event word layout and CTRL bit positions for laser_beam_sensor.
package laser_beam_sensor_pkg;

  localparam logic [1:0] AddrState = 2'd0;
  localparam logic [1:0] AddrEvent = 2'd1;
  localparam logic [1:0] AddrCount = 2'd2;
  localparam logic [1:0] AddrCtrl  = 2'd3;

  localparam int unsigned EvChanLsb  = 0;
  localparam int unsigned EvChanW    = 5;
  localparam int unsigned EvBreakBit = 8;
  localparam int unsigned EvPedalBit = 9;
  localparam int unsigned EvTsLsb    = 16;
  localparam int unsigned EvTsW      = 15;
  localparam int unsigned EvValidBit = 31;

  localparam int unsigned CtrlIrqEnBit  = 31;
  localparam int unsigned StatePedalBit = 31;
  localparam int unsigned CountOvfBit   = 16;

  function automatic logic [31:0] make_event(logic [EvChanW-1:0] chan, logic brk,
                                             logic pedal, logic [EvTsW-1:0] ts);
    logic [31:0] w;
    w = '0;
    w[EvChanLsb +: EvChanW] = chan;
    w[EvBreakBit]           = brk;
    w[EvPedalBit]           = pedal;
    w[EvTsLsb +: EvTsW]     = ts;
    w[EvValidBit]           = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/beam_debounce.sv
// One input channel: 2-flop synchroniser, stability counter and pending flag.
// The owner decides when a pending change is accepted via accept.
module beam_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic accept,
  output logic state,
  output logic pending
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CntMax = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q, s1_d;
  logic          s2_q, s2_d;
  logic          state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          mismatch;

  always_comb begin
    s1_d     = raw;
    s2_d     = s1_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    mismatch = (s2_q != state_q);
    pending  = mismatch && (cnt_q == CntMax);
    if (!mismatch) begin
      cnt_d = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
    // Saturated counter holds until the owner grants the flip.
    if (pending && accept) begin
      state_d = ~state_q;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      state_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/laser_beam_sensor.sv
// Debounced photodiode/pedal event recorder with event FIFO, Avalon-MM slave and IRQ.
// Optional build macro TIMESTAMP_EN adds a prescaled 15-bit timestamp to each event.
module laser_beam_sensor
  import laser_beam_sensor_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS    = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned FIFO_DEPTH      = 16,
  parameter int unsigned TS_PRESCALE     = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CHANNELS-1:0] photodiode,
  input  logic                    pedal,
  input  logic [1:0]              avs_address,
  input  logic                    avs_read,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  output logic [31:0]             avs_readdata,
  output logic                    irq
);

  localparam int unsigned N  = NUM_CHANNELS;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  // Channel N is the pedal.
  logic [N:0] raw_all, state_all, pending_all, accept_all;

  assign raw_all = {pedal, photodiode};

  for (genvar i = 0; i <= N; i++) begin : g_db
    beam_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk    (clk),
      .reset  (reset),
      .raw    (raw_all[i]),
      .accept (accept_all[i]),
      .state  (state_all[i]),
      .pending(pending_all[i])
    );
  end

  logic [N-1:0]   en_q, en_d;
  logic           irq_en_q, irq_en_d;
  logic           irq_q, irq_d;
  logic [31:0]    rdata_q, rdata_d;
  logic [N-1:0]   grant;
  logic [4:0]     grant_idx;
  logic           push_req;
  logic           push_brk;
  logic [EvTsW-1:0] ts_val;
  logic [31:0]    push_word;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    push_req  = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (!push_req && pending_all[i] && en_q[i]) begin
        grant[i]  = 1'b1;
        grant_idx = 5'(i);
        push_req  = 1'b1;
      end
    end
    // Disabled channels flip freely; enabled ones only when granted.
    accept_all    = {pending_all[N], pending_all[N-1:0] & (~en_q | grant)};
    push_brk      = |(grant & ~state_all[N-1:0]);
    push_word     = make_event(grant_idx, push_brk, state_all[N], ts_val);
  end

`ifdef TIMESTAMP_EN
  localparam int unsigned PW = (TS_PRESCALE > 1) ? $clog2(TS_PRESCALE) : 1;
  logic [PW-1:0]    presc_q, presc_d;
  logic [EvTsW-1:0] ts_q, ts_d;

  always_comb begin
    presc_d = presc_q + 1'b1;
    ts_d    = ts_q;
    if (presc_q == PW'(TS_PRESCALE - 1)) begin
      presc_d = '0;
      ts_d    = ts_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      ts_q    <= '0;
    end else begin
      presc_q <= presc_d;
      ts_q    <= ts_d;
    end
  end

  assign ts_val = ts_q;
`else
  localparam int unsigned unused_ts_prescale = TS_PRESCALE;
  assign ts_val = '0;
`endif

  // Event FIFO
  logic [31:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          empty, full, pop, flush, push, drop;

  always_comb begin
    empty    = (cnt_q == '0);
    full     = (cnt_q == (AW+1)'(FIFO_DEPTH));
    pop      = avs_read && (avs_address == AddrEvent) && !empty;
    flush    = avs_write && (avs_address == AddrCount);
    push     = push_req && !flush && (!full || pop);
    drop     = push_req && !flush && full && !pop;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !pop) cnt_d = cnt_q + 1'b1;
      if (pop && !push) cnt_d = cnt_q - 1'b1;
      if (drop) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_word;
  end

  // Register file
  logic unused_wdata;
  assign unused_wdata = ^avs_writedata;

  always_comb begin
    en_d     = en_q;
    irq_en_d = irq_en_q;
    if (avs_write && (avs_address == AddrCtrl)) begin
      en_d     = avs_writedata[N-1:0];
      irq_en_d = avs_writedata[CtrlIrqEnBit];
    end
    irq_d   = irq_en_q && !empty;
    rdata_d = '0;
    if (avs_read) begin
      unique case (avs_address)
        AddrState: begin
          rdata_d[N-1:0]        = state_all[N-1:0];
          rdata_d[StatePedalBit] = state_all[N];
        end
        AddrEvent: begin
          if (!empty) rdata_d = mem_q[rd_ptr_q];
        end
        AddrCount: begin
          rdata_d[15:0]        = 16'(cnt_q);
          rdata_d[CountOvfBit] = ovf_q;
        end
        AddrCtrl: begin
          rdata_d[N-1:0]       = en_q;
          rdata_d[CtrlIrqEnBit] = irq_en_q;
        end
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
      en_q     <= '1;
      irq_en_q <= 1'b0;
      irq_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
      en_q     <= en_d;
      irq_en_q <= irq_en_d;
      irq_q    <= irq_d;
      rdata_q  <= rdata_d;
    end
  end

  assign avs_readdata = rdata_q;
  assign irq          = irq_q;

endmodule
